// File: rtl/rst_sequencer.sv
// Reset release sequencer: waits for both MMCMs to hold lock, then releases
// the rx, tx and system resets in order; any lock loss restarts the sequence.
module rst_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP_CYCLES   = 16,
   parameter int LOSS_CNT_W         = 8
) (
   input  logic                  clkIn,
   input  logic                  rstIn,
   input  logic                  mmcm0LockedIn,
   input  logic                  mmcm1LockedIn,
   output logic                  rxRstOut,
   output logic                  txRstOut,
   output logic                  sysRstOut,
   output logic                  rstDoneOut,
   output logic [LOSS_CNT_W-1:0] lockLossCntOut
);

   localparam int MAX_CNT = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                            LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK, STABLE, REL_RX, REL_TX, REL_SYS, RUN
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync0;
   logic [SYNC_STAGES-1:0] sync1;
   logic                   lockedSync;

   assign lockedSync = sync0[SYNC_STAGES-1] & sync1[SYNC_STAGES-1];

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state          <= WAIT_LOCK;
         cnt            <= '0;
         sync0          <= '0;
         sync1          <= '0;
         rxRstOut       <= 1'b1;
         txRstOut       <= 1'b1;
         sysRstOut      <= 1'b1;
         rstDoneOut     <= 1'b0;
         lockLossCntOut <= '0;
      end else begin
         sync0 <= {sync0[SYNC_STAGES-2:0], mmcm0LockedIn};
         sync1 <= {sync1[SYNC_STAGES-2:0], mmcm1LockedIn};

         if (!lockedSync && state != WAIT_LOCK && state != STABLE) begin
            // Loss after at least one release: re-assert everything and log it.
            state      <= WAIT_LOCK;
            cnt        <= '0;
            rxRstOut   <= 1'b1;
            txRstOut   <= 1'b1;
            sysRstOut  <= 1'b1;
            rstDoneOut <= 1'b0;
            if (lockLossCntOut != '1)
               lockLossCntOut <= lockLossCntOut + LOSS_CNT_W'(1);
         end else begin
            case (state)
               WAIT_LOCK: begin
                  rxRstOut   <= 1'b1;
                  txRstOut   <= 1'b1;
                  sysRstOut  <= 1'b1;
                  rstDoneOut <= 1'b0;
                  cnt        <= '0;
                  if (lockedSync) state <= STABLE;
               end
               STABLE: begin
                  if (!lockedSync) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else if (cnt == STABLE_LAST) begin
                     state    <= REL_RX;
                     cnt      <= '0;
                     rxRstOut <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               REL_RX: begin
                  if (cnt == GAP_LAST) begin
                     state    <= REL_TX;
                     cnt      <= '0;
                     txRstOut <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               REL_TX: begin
                  if (cnt == GAP_LAST) begin
                     state     <= REL_SYS;
                     cnt       <= '0;
                     sysRstOut <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               REL_SYS: begin
                  if (cnt == GAP_LAST) begin
                     state      <= RUN;
                     cnt        <= '0;
                     rstDoneOut <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               RUN: ;
               default: state <= WAIT_LOCK;
            endcase
         end
      end
   end

endmodule
